// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage blocking data-memory access unit with load lane extraction.
// Optional MEM_MISALIGN_TRAP_EN: suppress misaligned half/word accesses and pulse MEM_misalign_o.
module mem_access_unit #(
  parameter int width = 32,
  parameter int MBE_W = width / 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               MEM_valid_i,
  input  logic               MEM_mem_read_i,
  input  logic               MEM_mem_write_i,
  input  logic [2:0]         MEM_funct3_i,
  input  logic [width-1:0]   MEM_alu_out_i,
  input  logic [width-1:0]   MEM_rs2_out_i,
  output logic               dmem_read_o,
  output logic               dmem_write_o,
  output logic [width-1:0]   dmem_address_o,
  output logic [width-1:0]   dmem_wdata_o,
  output logic [MBE_W-1:0]   dmem_mbe_o,
  input  logic               dmem_resp_i,
  input  logic [width-1:0]   dmem_rdata_i,
  output logic [width-1:0]   MEM_load_data_o,
  output logic               MEM_load_valid_o,
  output logic               MEM_stall_o
`ifdef MEM_MISALIGN_TRAP_EN
  , output logic             MEM_misalign_o
`endif
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_n;

  logic [width-1:0] addr_q, wdata_q, load_data_q;
  logic [MBE_W-1:0] mbe_q;
  logic [2:0]       funct3_q;
  logic             rd_q, wr_q, is_load_q;
  logic             req, issue, capture;
  logic [MBE_W-1:0] mbe_d;
  logic [width-1:0] wdata_d, ext_d, byte_sh, half_sh;

  assign req = MEM_valid_i & (MEM_mem_read_i | MEM_mem_write_i);

`ifdef MEM_MISALIGN_TRAP_EN
  logic mis;
  always_comb begin
    mis = 1'b0;
    if (MEM_funct3_i[1:0] == 2'd1)      mis = MEM_alu_out_i[0];
    else if (MEM_funct3_i[1:0] != 2'd0) mis = |MEM_alu_out_i[1:0];
  end
`endif

  // Store lane placement from the live EX inputs; latched on accept.
  always_comb begin
    mbe_d   = 4'b1111;
    wdata_d = MEM_rs2_out_i;
    case (MEM_funct3_i[1:0])
      2'd0: begin
        mbe_d   = 4'b0001 << MEM_alu_out_i[1:0];
        wdata_d = {4{MEM_rs2_out_i[7:0]}};
      end
      2'd1: begin
        mbe_d   = 4'b0011 << {MEM_alu_out_i[1], 1'b0};
        wdata_d = {2{MEM_rs2_out_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Load lane extraction uses the latched address/funct3.
  always_comb begin
    byte_sh = dmem_rdata_i >> {addr_q[1:0], 3'b000};
    half_sh = dmem_rdata_i >> {addr_q[1], 4'b0000};
    case (funct3_q[1:0])
      2'd0:    ext_d = {{24{byte_sh[7] & ~funct3_q[2]}}, byte_sh[7:0]};
      2'd1:    ext_d = {{16{half_sh[15] & ~funct3_q[2]}}, half_sh[15:0]};
      default: ext_d = dmem_rdata_i;
    endcase
  end

  always_comb begin
    state_n          = state;
    MEM_stall_o      = 1'b0;
    MEM_load_valid_o = 1'b0;
    issue            = 1'b0;
    capture          = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    MEM_misalign_o   = 1'b0;
`endif
    case (state)
      IDLE: begin
`ifdef MEM_MISALIGN_TRAP_EN
        MEM_misalign_o = req & mis;
        issue          = req & ~mis;
`else
        issue          = req;
`endif
        if (issue) begin
          MEM_stall_o = 1'b1;
          state_n     = BUSY;
        end
      end
      BUSY: begin
        MEM_stall_o = 1'b1;
        if (dmem_resp_i) begin
          capture = 1'b1;
          state_n = DONE;
        end
      end
      DONE: begin
        MEM_load_valid_o = is_load_q;
        state_n          = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      mbe_q       <= '0;
      funct3_q    <= '0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      is_load_q   <= 1'b0;
      load_data_q <= '0;
    end else begin
      state <= state_n;
      if (issue) begin
        addr_q    <= MEM_alu_out_i;
        wdata_q   <= wdata_d;
        mbe_q     <= mbe_d;
        funct3_q  <= MEM_funct3_i;
        is_load_q <= MEM_mem_read_i;
        rd_q      <= MEM_mem_read_i;
        wr_q      <= ~MEM_mem_read_i;
      end
      if (capture) begin
        rd_q <= 1'b0;
        wr_q <= 1'b0;
        if (is_load_q) load_data_q <= ext_d;
      end
    end
  end

  assign dmem_read_o     = rd_q;
  assign dmem_write_o    = wr_q;
  assign dmem_address_o  = (rd_q | wr_q) ? {addr_q[width-1:2], 2'b00} : '0;
  assign dmem_wdata_o    = (rd_q | wr_q) ? wdata_q : '0;
  assign dmem_mbe_o      = (rd_q | wr_q) ? mbe_q : '0;
  assign MEM_load_data_o = load_data_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - scoreboard bench for mem_access_unit (directed vectors).
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0, mrd = 1'b0, mwr = 1'b0;
  logic [2:0]  f3 = 3'd0;
  logic [31:0] alu = '0, rs2 = '0, rdata = '0;
  logic        resp = 1'b0;
  logic        d_rd, d_wr, load_valid, stall;
  logic [31:0] d_addr, d_wdata, load_data;
  logic [3:0]  d_mbe;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  int checks = 0, errors = 0;
  int stall_cnt = 0, req_cnt = 0;
  logic prev_req = 1'b0;
  logic [69:0] req_q[$];
  logic [31:0] load_q[$];

  mem_access_unit dut (
    .clk(clk), .rst(rst),
    .MEM_valid_i(valid), .MEM_mem_read_i(mrd), .MEM_mem_write_i(mwr),
    .MEM_funct3_i(f3), .MEM_alu_out_i(alu), .MEM_rs2_out_i(rs2),
    .dmem_read_o(d_rd), .dmem_write_o(d_wr), .dmem_address_o(d_addr),
    .dmem_wdata_o(d_wdata), .dmem_mbe_o(d_mbe),
    .dmem_resp_i(resp), .dmem_rdata_i(rdata),
    .MEM_load_data_o(load_data), .MEM_load_valid_o(load_valid),
    .MEM_stall_o(stall)
`ifdef MEM_MISALIGN_TRAP_EN
    , .MEM_misalign_o(misalign)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops a request on each new dmem request, a load on each load_valid cycle.
  always @(negedge clk) begin
    logic cur;
    cur = d_rd | d_wr;
    if (stall) stall_cnt++;
    if (cur) req_cnt++;
    if (cur && !prev_req) begin
      if (req_q.size() == 0) chk("unexpected_request", {d_rd, d_wr, d_addr, d_wdata, d_mbe}, '0);
      else chk("request", {d_rd, d_wr, d_addr, d_wdata, d_mbe}, req_q.pop_front());
    end
    prev_req = cur;
    if (load_valid) begin
      if (load_q.size() == 0) chk("unexpected_load_valid", {38'd0, load_data}, {38'd0, 32'hFFFF_FFFF} ^ {38'd0, load_data});
      else chk("load_data", {38'd0, load_data}, {38'd0, load_q.pop_front()});
    end
  end

  task automatic op(input logic r, input logic w, input logic [2:0] fn, input logic [31:0] a,
                    input logic [31:0] d, input logic [31:0] rdat, input int lat,
                    input logic [31:0] e_addr, input logic [31:0] e_wdata, input logic [3:0] e_mbe,
                    input logic [31:0] e_load);
    valid = 1'b1; mrd = r; mwr = w; f3 = fn; alu = a; rs2 = d;
    req_q.push_back({r, ~r, e_addr, e_wdata, e_mbe});
    if (r) load_q.push_back(e_load);
    stall_cnt = 0; req_cnt = 0;
    @(posedge clk); #1;
    repeat (lat - 1) begin @(posedge clk); #1; end
    resp = 1'b1; rdata = rdat;
    @(posedge clk); #1;
    resp = 1'b0;
    @(posedge clk); #1;
    chk("stall_cycles", 70'(stall_cnt), 70'(lat + 1));
    chk("request_hold_cycles", 70'(req_cnt), 70'(lat));
    valid = 1'b0; mrd = 1'b0; mwr = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {d_rd, d_wr, d_addr, d_wdata, d_mbe},
        70'd0);
    chk("reset_misc", {38'd0, load_data}, 70'd0);
    chk("reset_stall", {68'd0, stall, load_valid}, 70'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    op(1, 0, 3'd2, 32'h100, 32'h11223344, 32'hDEADBEEF, 2, 32'h100, 32'h11223344, 4'hF, 32'hDEADBEEF);
    op(1, 0, 3'd0, 32'h103, 32'h11223344, 32'h80123456, 1, 32'h100, 32'h44444444, 4'h8, 32'hFFFFFF80);
    op(1, 0, 3'd4, 32'h103, 32'h11223344, 32'h80123456, 3, 32'h100, 32'h44444444, 4'h8, 32'h00000080);
    op(0, 1, 3'd1, 32'h102, 32'h1234ABCD, 32'h0, 2, 32'h100, 32'hABCDABCD, 4'hC, 32'h0);
    op(1, 0, 3'd1, 32'h102, 32'h11223344, 32'h80010000, 1, 32'h100, 32'h33443344, 4'hC, 32'hFFFF8001);
    op(1, 0, 3'd5, 32'h100, 32'h11223344, 32'h1234F00F, 1, 32'h100, 32'h33443344, 4'h3, 32'h0000F00F);
    op(1, 1, 3'd2, 32'h200, 32'h55667788, 32'h01020304, 1, 32'h200, 32'h55667788, 4'hF, 32'h01020304);

    // No mem op, or no valid instruction: nothing issued, no stall.
    valid = 1'b1; mrd = 1'b0; mwr = 1'b0; #1;
    chk("no_op_stall", {69'd0, stall}, 70'd0);
    @(posedge clk); #1;
    valid = 1'b0; mrd = 1'b1; #1;
    chk("not_valid_stall", {69'd0, stall}, 70'd0);
    @(posedge clk); #1;
    mrd = 1'b0;
    // Stray response while idle must be ignored.
    resp = 1'b1; @(posedge clk); #1; resp = 1'b0;
    @(posedge clk); #1;
    chk("stray_resp_state", {69'd0, stall}, 70'd0);

    op(1, 0, 3'd2, 32'h10, 32'h11223344, 32'h0BADF00D, 1, 32'h10, 32'h11223344, 4'hF, 32'h0BADF00D);
    op(0, 1, 3'd2, 32'h14, 32'hCAFEBABE, 32'h0, 1, 32'h14, 32'hCAFEBABE, 4'hF, 32'h0);
    chk("load_data_held", {38'd0, load_data}, {38'd0, 32'h0BADF00D});

    // Reset while BUSY: dmem_* drops, following resp is ignored, load data cleared.
    valid = 1'b1; mrd = 1'b1; f3 = 3'd2; alu = 32'h300; rs2 = 32'h99;
    req_q.push_back({1'b1, 1'b0, 32'h300, 32'h99, 4'hF});
    @(posedge clk); #1;
    valid = 1'b0; mrd = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_busy_dmem", {d_rd, d_wr, d_addr, d_wdata, d_mbe}, 70'd0);
    chk("rst_busy_load_data", {38'd0, load_data}, 70'd0);
    rst = 1'b0; resp = 1'b1; rdata = 32'h12345678;
    @(posedge clk); #1;
    resp = 1'b0;
    chk("rst_busy_stall", {69'd0, stall}, 70'd0);
    @(posedge clk); #1;

`ifdef MEM_MISALIGN_TRAP_EN
    valid = 1'b1; mrd = 1'b1; f3 = 3'd2; alu = 32'h101; #1;
    chk("misalign_pulse", {68'd0, misalign, stall}, {68'd0, 2'b10});
    @(posedge clk); #1;
    valid = 1'b0; mrd = 1'b0; #1;
    chk("misalign_clear", {68'd0, misalign, stall}, 70'd0);
    @(posedge clk); #1;
`else
    op(1, 0, 3'd2, 32'h101, 32'h11223344, 32'hA5A5A5A5, 1, 32'h100, 32'h11223344, 4'hF, 32'hA5A5A5A5);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("requests_outstanding", 70'(req_q.size()), 70'd0);
    chk("loads_outstanding", 70'(load_q.size()), 70'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
